// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: immediate-extension mode encodings.
package cpu_pkg;

   typedef enum logic [1:0] {
      MODE_ZERO  = 2'd0,
      MODE_SIGN  = 2'd1,
      MODE_BR    = 2'd2,
      MODE_UPPER = 2'd3
   } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero/sign extend, branch offset, load-upper.
// Also used by the decode-stage hazard logic, so it must stay free of state.
module imm_ext_core
   import cpu_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2
) (
   input  logic [IN_W-1:0]  i_imm,
   input  logic [1:0]       i_mode,
   output logic [OUT_W-1:0] o_data,
   output logic             o_ovf
);

   localparam int EXT_W = OUT_W + SHIFT;

   logic [OUT_W-1:0] w_zero;
   logic [OUT_W-1:0] w_sign;
   logic [OUT_W-1:0] w_upper;
   logic [EXT_W-1:0] w_br;
   logic             w_br_ovf;

   assign w_zero  = OUT_W'(i_imm);
   assign w_sign  = OUT_W'($signed(i_imm));
   assign w_upper = w_zero << (OUT_W - IN_W);
   assign w_br    = EXT_W'($signed(i_imm)) << SHIFT;

   // Overflow: the bits shifted out must all match the retained sign bit.
   generate
      if (SHIFT > 0) begin : g_ovf
         assign w_br_ovf = (w_br[EXT_W-1 -: SHIFT] != {SHIFT{w_br[OUT_W-1]}});
      end else begin : g_no_ovf
         assign w_br_ovf = 1'b0;
      end
   endgenerate

   always_comb begin
      o_data = w_zero;
      o_ovf  = 1'b0;
      case (imm_mode_e'(i_mode))
         MODE_ZERO:  o_data = w_zero;
         MODE_SIGN:  o_data = w_sign;
         MODE_BR: begin
            o_data = w_br[OUT_W-1:0];
            o_ovf  = w_br_ovf;
         end
         MODE_UPPER: o_data = w_upper;
         default:    o_data = w_zero;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with valid/ready handshake, one-entry skid
// buffer for full throughput under backpressure, and an output transfer counter.
module imm_ext_pipe
   import cpu_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] xfer_cnt
);

   logic [OUT_W-1:0] w_core_data;
   logic             w_core_ovf;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_out_load;

   logic             r_in_ready;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_ovf;
   logic             r_skid_valid;
   logic [OUT_W-1:0] r_skid_data;
   logic             r_skid_ovf;
   logic [CNT_W-1:0] r_cnt;
   logic             r_skid_valid_next;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_core (
      .i_imm  (in_imm),
      .i_mode (in_mode),
      .o_data (w_core_data),
      .o_ovf  (w_core_ovf)
   );

   assign in_ready   = r_in_ready & ~rst;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = r_out_valid & out_ready;
   // Output register may take a new word when empty or draining this cycle.
   assign w_out_load = ~r_out_valid | out_ready;

   always_comb begin
      r_skid_valid_next = r_skid_valid;
      if (w_out_load)
         r_skid_valid_next = 1'b0;
      else if (w_in_xfer)
         r_skid_valid_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_ovf    <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_ovf   <= 1'b0;
         r_cnt        <= '0;
      end else begin
         if (w_out_xfer)
            r_cnt <= r_cnt + 1'b1;

         if (w_out_load) begin
            if (r_skid_valid) begin
               r_out_valid <= 1'b1;
               r_out_data  <= r_skid_data;
               r_out_ovf   <= r_skid_ovf;
            end else if (w_in_xfer) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_core_data;
               r_out_ovf   <= w_core_ovf;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else if (w_in_xfer) begin
            r_skid_data <= w_core_data;
            r_skid_ovf  <= w_core_ovf;
         end

         r_skid_valid <= r_skid_valid_next;
         r_in_ready   <= ~r_skid_valid_next;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;
   assign xfer_cnt  = r_cnt;

endmodule
